// File: rtl/fifo_word_packer.sv
// Byte-to-word packer draining an 8-bit sync FIFO into little-endian words.
// Partial words on FLUSH carry a byte mask; output is a valid/ready port.
module fifo_word_packer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [DATA_W-1:0]        FIFO_DATA,
  input  logic                     FIFO_EF,
  input  logic                     FIFO_UF,
  output logic                     FIFO_RD_EN,
  input  logic                     FLUSH,
  output logic [DATA_W*LANES-1:0]  WORD_OUT,
  output logic [LANES-1:0]         BYTE_MASK,
  output logic                     WORD_VALID,
  input  logic                     WORD_READY,
  output logic [CNT_W-1:0]         WORD_COUNT,
  output logic                     ERR
);

  localparam int BC_W = $clog2(LANES + 1);
  localparam int LI_W = $clog2(LANES);

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    EMIT
  } state_e;

  state_e state_q, state_d;
  logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [BC_W-1:0] cnt_n, emit_cnt;
  logic rd_pend_q, rd_pend_d;
  logic flush_pend_q, flush_pend_d;
  logic flush_clr, do_emit, rd_en;
  logic [LANES-1:0][DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W*LANES-1:0] word_q, word_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [LANES:0] mask_w;
  logic valid_q, valid_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    word_d     = word_q;
    mask_d     = mask_q;
    valid_d    = valid_q;
    count_d    = count_q;
    flush_clr  = 1'b0;
    do_emit    = 1'b0;
    cnt_n      = byte_cnt_q;
    emit_cnt   = byte_cnt_q;
    mask_w     = '0;
    rd_en = (state_q == FILL) && !FIFO_EF && !flush_pend_q
         && ((byte_cnt_q + BC_W'(rd_pend_q)) < BC_W'(LANES));
    // a pending read outside FILL means a byte arrived with nowhere to go
    err_d = err_q | FIFO_UF | (rd_pend_q && state_q != FILL);
    unique case (state_q)
      FILL: begin
        if (rd_pend_q) begin
          asm_d[byte_cnt_q[LI_W-1:0]] = FIFO_DATA;
          cnt_n = byte_cnt_q + BC_W'(1);
        end
        byte_cnt_d = cnt_n;
        emit_cnt   = cnt_n;
        if (cnt_n == BC_W'(LANES)) begin
          do_emit = 1'b1;
        end else if (flush_pend_q) begin
          if (rd_pend_q) begin
            state_d = DRAIN;
          end else begin
            flush_clr = 1'b1;
            do_emit   = (cnt_n != '0);
          end
        end
      end
      DRAIN: begin
        do_emit   = 1'b1;
        flush_clr = 1'b1;
      end
      EMIT: begin
        if (WORD_READY) begin
          valid_d = 1'b0;
          count_d = count_q + CNT_W'(1);
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    if (do_emit) begin
      mask_w     = ((LANES + 1)'(1) << emit_cnt) - (LANES + 1)'(1);
      word_d     = asm_d;
      mask_d     = mask_w[LANES-1:0];
      valid_d    = 1'b1;
      byte_cnt_d = '0;
      asm_d      = '0;
      state_d    = EMIT;
    end
    flush_pend_d = FLUSH | (flush_pend_q & ~flush_clr);
    rd_pend_d    = rd_en;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= FILL;
      byte_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      asm_q        <= '0;
      word_q       <= '0;
      mask_q       <= '0;
      valid_q      <= 1'b0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      rd_pend_q    <= rd_pend_d;
      flush_pend_q <= flush_pend_d;
      asm_q        <= asm_d;
      word_q       <= word_d;
      mask_q       <= mask_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  assign FIFO_RD_EN = rd_en;
  assign WORD_OUT   = word_q;
  assign BYTE_MASK  = mask_q;
  assign WORD_VALID = valid_q;
  assign WORD_COUNT = count_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: behavioural FIFO, byte-list
// reference model feeding an expected-word queue, decoupled monitor.
module tb_fifo_word_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [7:0]  fifo_data = '0;
  logic        fifo_ef = 1'b1;
  logic        fifo_uf = 1'b0;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic [31:0] word_out;
  logic [3:0]  byte_mask;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [15:0] word_count;
  logic        err;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  m;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pend[$];
  logic [7:0] fifo_q[$];
  int         fifo_cnt = 0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  int         tests = 0;
  int         fails = 0;
  int         acc_cnt = 0;
  int         ready_mode = 0;
  int         inv_prints = 0;

  fifo_word_packer dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .FIFO_DATA  (fifo_data),
    .FIFO_EF    (fifo_ef),
    .FIFO_UF    (fifo_uf),
    .FIFO_RD_EN (fifo_rd_en),
    .FLUSH      (flush),
    .WORD_OUT   (word_out),
    .BYTE_MASK  (byte_mask),
    .WORD_VALID (word_valid),
    .WORD_READY (word_ready),
    .WORD_COUNT (word_count),
    .ERR        (err)
  );

  // 8x32 sync FIFO: data registered one cycle after a read
  always @(posedge clk) begin
    fifo_uf <= fifo_rd_en && (fifo_q.size() == 0);
    if (fifo_rd_en && fifo_q.size() != 0)
      fifo_data <= fifo_q.pop_front();
    if (wr_en && fifo_q.size() < 32)
      fifo_q.push_back(wr_data);
    fifo_cnt = fifo_q.size();
    fifo_ef <= (fifo_q.size() == 0);
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       word_ready = 1'b1;
      1:       word_ready = 1'($urandom_range(0, 1));
      default: word_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      acc_cnt = 0;
    end else begin
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h mask %b expected none",
                   word_out, byte_mask);
        end else begin
          e = exp_q.pop_front();
          check("word", word_out, e.w);
          check("mask", {28'd0, byte_mask}, {28'd0, e.m});
          check("count", {16'd0, word_count}, {16'd0, acc_cnt[15:0]});
        end
        acc_cnt++;
      end
      tests++;
      if ((fifo_rd_en && fifo_ef) || err || fifo_uf
          || (word_valid && !word_ready && fifo_rd_en)) begin
        fails++;
        if (inv_prints < 10)
          $display("FAIL invariant: rd_en=%b ef=%b err=%b uf=%b valid=%b ready=%b expected no violation",
                   fifo_rd_en, fifo_ef, err, fifo_uf, word_valid, word_ready);
        inv_prints++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    pend.push_back(b);
    if (pend.size() == 4) begin
      e.w = {pend[3], pend[2], pend[1], pend[0]};
      e.m = 4'hF;
      exp_q.push_back(e);
      pend.delete();
    end
  endtask

  task automatic model_flush();
    exp_t e;
    if (pend.size() > 0) begin
      e.w = '0;
      for (int i = 0; i < pend.size(); i++)
        e.w[8*i +: 8] = pend[i];
      e.m = 4'((1 << pend.size()) - 1);
      exp_q.push_back(e);
      pend.delete();
    end
  endtask

  task automatic push(input logic [7:0] b);
    int g = 0;
    while (fifo_cnt >= 32 && g < 1000) begin
      tick();
      g++;
    end
    if (g >= 1000) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: got fifo_cnt %0d expected <32", fifo_cnt);
    end
    wr_en   = 1'b1;
    wr_data = b;
    model_byte(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_empty();
    int g = 0;
    while (fifo_cnt != 0 && g < 2000) begin
      tick();
      g++;
    end
    if (g >= 2000) begin
      tests++;
      fails++;
      $display("FAIL empty_timeout: got fifo_cnt %0d expected 0", fifo_cnt);
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    wait_empty();
    while (exp_q.size() != 0 && g < 2000) begin
      tick();
      g++;
    end
    if (g >= 2000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d words pending expected 0",
               exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic do_flush();
    wait_empty();
    flush = 1'b1;
    model_flush();
    tick();
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    pend.delete();
    exp_q.delete();
    check("rst_valid", {31'd0, word_valid}, 32'd0);
    check("rst_word", word_out, 32'd0);
    check("rst_mask", {28'd0, byte_mask}, 32'd0);
    check("rst_count", {16'd0, word_count}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    ready_mode = 0;
    do_reset();

    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_drain();
    check("t1_count", {16'd0, word_count}, 32'd2);

    push(8'h11);
    push(8'h22);
    push(8'h33);
    do_flush();
    wait_drain();
    check("t2_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("t2_ef", {31'd0, fifo_ef}, 32'd1);
    check("t2_count", {16'd0, word_count}, 32'd3);

    do_flush();
    repeat (10) begin
      tick();
      check("t4_no_valid", {31'd0, word_valid}, 32'd0);
    end
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    wait_drain();

    push(8'h5A);
    push(8'h5B);
    wait_empty();
    repeat (3) tick();
    do_reset();
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    wait_drain();
    check("t5_count", {16'd0, word_count}, 32'd1);

    do_reset();
    ready_mode = 2;
    for (int i = 1; i <= 32; i++) push(8'(i));
    repeat (20) begin
      tick();
      check("t3_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      check("t3_valid", {31'd0, word_valid}, 32'd1);
      check("t3_hold", word_out, 32'h04030201);
    end
    ready_mode = 0;
    wait_drain();
    check("t3_count", {16'd0, word_count}, 32'd8);

    do_reset();
    ready_mode = 1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_flush();
      end else begin
        push(8'($urandom));
        if ($urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 4)) tick();
      end
    end
    do_flush();
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
